// File: rtl/mtm_alu_serializer.sv
// Output stage of the mtm ALU: latches one result or error word per handshake and
// emits it on sout as 11-bit packets (start, type, byte MSB first, stop).
module mtm_alu_serializer #(
   parameter int unsigned INTER_PKT_GAP   = 0,
   parameter int unsigned INTER_FRAME_GAP = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_err,
   input  logic [31:0] C,
   input  logic [3:0]  flags,
   input  logic [5:0]  err_flags,
   output logic        sout,
   output logic        busy
);

   typedef enum logic [2:0] {IDLE, START, TYPE, BITS, STOP, GAP, FGAP} state_t;

   localparam logic [2:0]  LAST_PKT     = 3'd4;
   localparam logic [15:0] PKT_GAP_M1   = 16'(INTER_PKT_GAP - 1);
   localparam logic [15:0] FRAME_GAP_M1 = 16'(INTER_FRAME_GAP - 1);

   state_t      state_reg, state_next;
   logic [2:0]  pkt_cnt_reg, pkt_cnt_next;
   logic [2:0]  bit_cnt_reg, bit_cnt_next;
   logic [15:0] gap_cnt_reg, gap_cnt_next;
   logic [31:0] c_reg, c_next;
   logic [7:0]  ctl_reg, ctl_next;
   logic        sout_reg, sout_next;
   logic        in_ready_reg, in_ready_next;
   logic        busy_reg, busy_next;
   logic [7:0]  cur_byte;

   // CRC3 (x^3+x+1, init 0) shifted in MSB first over {C, 1'b0, flags}
   function automatic logic [2:0] crc3(input logic [36:0] msg);
      logic [2:0] crc;
      logic       fb;
      crc = 3'b000;
      for (int i = 36; i >= 0; i--) begin
         fb  = crc[2] ^ msg[i];
         crc = {crc[1], crc[0] ^ fb, fb};
      end
      return crc;
   endfunction

   // Error frames start with pkt_cnt at LAST_PKT so they share the CTL path
   always_comb begin
      case (pkt_cnt_reg)
         3'd0:    cur_byte = c_reg[31:24];
         3'd1:    cur_byte = c_reg[23:16];
         3'd2:    cur_byte = c_reg[15:8];
         3'd3:    cur_byte = c_reg[7:0];
         default: cur_byte = ctl_reg;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         pkt_cnt_reg  <= 3'd0;
         bit_cnt_reg  <= 3'd0;
         gap_cnt_reg  <= 16'd0;
         c_reg        <= 32'd0;
         ctl_reg      <= 8'd0;
         sout_reg     <= 1'b1;
         in_ready_reg <= 1'b1;
         busy_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         pkt_cnt_reg  <= pkt_cnt_next;
         bit_cnt_reg  <= bit_cnt_next;
         gap_cnt_reg  <= gap_cnt_next;
         c_reg        <= c_next;
         ctl_reg      <= ctl_next;
         sout_reg     <= sout_next;
         in_ready_reg <= in_ready_next;
         busy_reg     <= busy_next;
      end
   end

   // Outputs are computed for the state being entered, so sout shows the bit of state_reg
   always_comb begin
      state_next    = state_reg;
      pkt_cnt_next  = pkt_cnt_reg;
      bit_cnt_next  = bit_cnt_reg;
      gap_cnt_next  = gap_cnt_reg;
      c_next        = c_reg;
      ctl_next      = ctl_reg;
      sout_next     = 1'b1;
      in_ready_next = 1'b0;
      busy_next     = 1'b1;
      case (state_reg)
         IDLE: begin
            in_ready_next = 1'b1;
            busy_next     = 1'b0;
            if (in_valid) begin
               state_next    = START;
               sout_next     = 1'b0;
               in_ready_next = 1'b0;
               busy_next     = 1'b1;
               if (in_err) begin
                  pkt_cnt_next = LAST_PKT;
                  ctl_next     = {1'b1, err_flags, ^{1'b1, err_flags}};
               end else begin
                  pkt_cnt_next = 3'd0;
                  c_next       = C;
                  ctl_next     = {1'b0, flags, crc3({C, 1'b0, flags})};
               end
            end
         end
         START: begin
            state_next = TYPE;
            sout_next  = (pkt_cnt_reg == LAST_PKT);
         end
         TYPE: begin
            state_next   = BITS;
            bit_cnt_next = 3'd7;
            sout_next    = cur_byte[7];
         end
         BITS: begin
            if (bit_cnt_reg == 3'd0) begin
               state_next = STOP;
            end else begin
               bit_cnt_next = bit_cnt_reg - 3'd1;
               sout_next    = cur_byte[bit_cnt_reg - 3'd1];
            end
         end
         STOP: begin
            if (pkt_cnt_reg == LAST_PKT) begin
               if (INTER_FRAME_GAP != 0) begin
                  state_next   = FGAP;
                  gap_cnt_next = FRAME_GAP_M1;
               end else begin
                  state_next    = IDLE;
                  in_ready_next = 1'b1;
                  busy_next     = 1'b0;
               end
            end else begin
               pkt_cnt_next = pkt_cnt_reg + 3'd1;
               if (INTER_PKT_GAP != 0) begin
                  state_next   = GAP;
                  gap_cnt_next = PKT_GAP_M1;
               end else begin
                  state_next = START;
                  sout_next  = 1'b0;
               end
            end
         end
         GAP: begin
            if (gap_cnt_reg == 16'd0) begin
               state_next = START;
               sout_next  = 1'b0;
            end else begin
               gap_cnt_next = gap_cnt_reg - 16'd1;
            end
         end
         FGAP: begin
            if (gap_cnt_reg == 16'd0) begin
               state_next    = IDLE;
               in_ready_next = 1'b1;
               busy_next     = 1'b0;
            end else begin
               gap_cnt_next = gap_cnt_reg - 16'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign sout     = sout_reg;
   assign in_ready = in_ready_reg;
   assign busy     = busy_reg;

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Scoreboard bench: stimulus pushes expected packets/ready-low lengths, monitors decode
// sout and in_ready of whichever DUT (no-gap or gapped) is currently selected.
module tb_mtm_alu_serializer;

   localparam int PG1 = 2;
   localparam int FG1 = 3;

   typedef struct {
      logic [10:0] pkt;
      int          gap;
   } exp_pkt_t;

   logic        clk, rst_n, in_valid, in_err, sel;
   logic [31:0] C_in;
   logic [3:0]  flags_in;
   logic [5:0]  err_in;
   logic        ready0, sout0, busy0, ready1, sout1, busy1;
   logic        in_valid0, in_valid1, cur_ready, cur_sout, cur_busy;

   exp_pkt_t    exp_pkts[$];
   int          exp_len[$];
   int          n_checks = 0;
   int          n_fail   = 0;

   assign in_valid0 = in_valid & ~sel;
   assign in_valid1 = in_valid & sel;
   assign cur_ready = sel ? ready1 : ready0;
   assign cur_sout  = sel ? sout1 : sout0;
   assign cur_busy  = sel ? busy1 : busy0;

   mtm_alu_serializer u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(ready0),
      .in_err(in_err), .C(C_in), .flags(flags_in), .err_flags(err_in),
      .sout(sout0), .busy(busy0)
   );

   mtm_alu_serializer #(.INTER_PKT_GAP(PG1), .INTER_FRAME_GAP(FG1)) u_dut_gap (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(ready1),
      .in_err(in_err), .C(C_in), .flags(flags_in), .err_flags(err_in),
      .sout(sout1), .busy(busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference CRC: remainder of M(x)*x^3 divided by x^3+x+1 (long division)
   function automatic logic [2:0] crc_model(input logic [31:0] c, input logic [3:0] f);
      logic [39:0] d;
      d = {c, 1'b0, f, 3'b000};
      for (int i = 39; i >= 3; i--)
         if (d[i]) d[i -: 4] = d[i -: 4] ^ 4'b1011;
      return d[2:0];
   endfunction

   function automatic logic [10:0] mk_pkt(input logic typ, input logic [7:0] b);
      return {1'b0, typ, b, 1'b1};
   endfunction

   task automatic push_frame(input bit err, input logic [31:0] c, input logic [3:0] f,
                             input logic [5:0] e, input int first_gap);
      int       pg, fg;
      exp_pkt_t ep;
      logic [7:0] ctl;
      pg = sel ? PG1 : 0;
      fg = sel ? FG1 : 0;
      if (err) begin
         ctl = 8'h80 | (8'(e) << 1) | 8'(1 - ($countones(e) % 2));
         ep.pkt = mk_pkt(1'b1, ctl);
         ep.gap = first_gap;
         exp_pkts.push_back(ep);
         exp_len.push_back(11 + fg);
      end else begin
         for (int k = 0; k < 4; k++) begin
            ep.pkt = mk_pkt(1'b0, 8'((c >> (24 - 8 * k)) & 32'hFF));
            ep.gap = (k == 0) ? first_gap : pg;
            exp_pkts.push_back(ep);
         end
         ctl = {1'b0, f, crc_model(c, f)};
         ep.pkt = mk_pkt(1'b1, ctl);
         ep.gap = pg;
         exp_pkts.push_back(ep);
         exp_len.push_back(55 + 4 * pg + fg);
      end
   endtask

   task automatic fail_now(input string name, input int got, input int want);
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
   endtask

   task automatic check(input string name, input int got, input int want);
      n_checks++;
      if (got != want) fail_now(name, got, want);
   endtask

   // Present a word and hold in_valid until it is accepted
   task automatic issue(input bit err, input logic [31:0] c, input logic [3:0] f,
                        input logic [5:0] e, input int first_gap, input bit hold);
      int n;
      in_valid = 1'b1; in_err = err; C_in = c; flags_in = f; err_in = e;
      n = 0;
      while (!cur_ready && n < 500) begin
         @(posedge clk); #1; n++;
      end
      if (!cur_ready) begin
         n_checks++;
         fail_now("accept_timeout", 0, 1);
         in_valid = 1'b0;
         return;
      end
      push_frame(err, c, f, e, first_gap);
      @(posedge clk); #1;
      if (!hold) in_valid = 1'b0;
   endtask

   // Packet monitor
   bit          in_pkt = 0;
   int          nbits = 0;
   int          idle_cnt = 0;
   logic [10:0] shreg;
   always @(negedge clk) begin
      exp_pkt_t ep;
      if (!rst_n) begin
         in_pkt = 0; idle_cnt = 0;
      end else if (!in_pkt) begin
         if (cur_sout == 1'b0) begin
            in_pkt = 1; nbits = 1; shreg = 11'd0;
         end else idle_cnt++;
      end else begin
         shreg = {shreg[9:0], cur_sout};
         nbits++;
         if (nbits == 11) begin
            in_pkt = 0;
            if (exp_pkts.size() == 0) begin
               n_checks++;
               fail_now("unexpected_pkt", int'(shreg), 0);
            end else begin
               ep = exp_pkts.pop_front();
               $display("pkt %03h expected %03h idle %0d", shreg, ep.pkt, idle_cnt);
               check("pkt", int'(shreg), int'(ep.pkt));
               if (ep.gap >= 0) check("pkt_gap", idle_cnt, ep.gap);
            end
            idle_cnt = 0;
         end
      end
   end

   // in_ready low-duration and busy monitor
   int low_cnt = 0;
   always @(negedge clk) begin
      int want;
      if (!rst_n) low_cnt = 0;
      else begin
         check("busy", int'(cur_busy), int'(!cur_ready));
         if (!cur_ready) low_cnt++;
         else if (low_cnt > 0) begin
            if (exp_len.size() == 0) begin
               n_checks++;
               fail_now("unexpected_frame_len", low_cnt, 0);
            end else begin
               want = exp_len.pop_front();
               check("ready_low_len", low_cnt, want);
            end
            low_cnt = 0;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got running required finished");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      logic [31:0] rc;
      rst_n = 1'b0; sel = 1'b0; in_valid = 1'b0; in_err = 1'b0;
      C_in = 32'd0; flags_in = 4'd0; err_in = 6'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_sout0", int'(sout0), 1);
      check("rst_ready0", int'(ready0), 1);
      check("rst_busy0", int'(busy0), 0);
      check("rst_sout1", int'(sout1), 1);
      check("rst_ready1", int'(ready1), 1);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed result and error frames
      issue(1'b0, 32'hDEADBEEF, 4'b0000, 6'd0, -1, 1'b0);
      issue(1'b1, 32'h0, 4'h0, 6'b100100, -1, 1'b0);
      issue(1'b1, 32'h0, 4'h0, 6'b010010, -1, 1'b0);

      // Random mix
      for (int i = 0; i < 16; i++) begin
         issue(($urandom_range(0, 3) == 0), $urandom, 4'($urandom), 6'($urandom), -1, 1'b0);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end

      // Inputs scrambled while the frame is on the line
      for (int i = 0; i < 3; i++) begin
         issue(1'b0, $urandom, 4'($urandom), 6'd0, -1, 1'b0);
         for (int k = 0; k < 40; k++) begin
            C_in = $urandom; flags_in = 4'($urandom); err_in = 6'($urandom); in_err = 1'($urandom);
            @(posedge clk); #1;
         end
      end

      // in_valid held high, alternating results, back-to-back frames
      for (int i = 0; i < 6; i++) begin
         rc = (i % 2 == 0) ? 32'hA5A5_0F0F : 32'h1234_5678 + 32'(i);
         issue(1'b0, rc, 4'(i * 3), 6'd0, (i == 0) ? -1 : 1, (i != 5));
      end

      // Reset mid-frame during data bits of packet 2
      n = 0;
      while (!cur_ready && n < 200) begin @(posedge clk); #1; n++; end
      issue(1'b0, 32'hCAFE_F00D, 4'b1010, 6'd0, -1, 1'b0);
      repeat (26) @(posedge clk);
      #3;
      rst_n = 1'b0;
      exp_pkts.delete();
      exp_len.delete();
      #1;
      check("midrst_sout", int'(cur_sout), 1);
      check("midrst_ready", int'(cur_ready), 1);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      issue(1'b0, 32'h0BAD_BEEF, 4'b0110, 6'd0, -1, 1'b0);

      // Gapped instance
      n = 0;
      while (!cur_ready && n < 200) begin @(posedge clk); #1; n++; end
      sel = 1'b1;
      issue(1'b0, 32'hDEADBEEF, 4'b1001, 6'd0, -1, 1'b0);
      issue(1'b0, $urandom, 4'($urandom), 6'd0, 1 + FG1, 1'b1);
      issue(1'b1, 32'h0, 4'h0, 6'b110011, 1 + FG1, 1'b0);
      issue(1'b0, $urandom, 4'($urandom), 6'd0, -1, 1'b0);

      n = 0;
      while ((exp_pkts.size() != 0 || exp_len.size() != 0) && n < 2000) begin
         @(posedge clk); n++;
      end
      repeat (3) @(posedge clk);
      #1;
      check("exp_pkts_drained", exp_pkts.size(), 0);
      check("exp_len_drained", exp_len.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
